// File: rtl/shadow_reg_seq_pkg.sv
// Shared types for the shadowed-register update sequencer.
package shadow_reg_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      WR1   = 3'd2,
      WR2   = 3'd3,
      RESP  = 3'd4,
      FATAL = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK     = 2'd0,
      ERR_UPDATE = 2'd1,
      ERR_PHASE  = 2'd2,
      ERR_FATAL  = 2'd3
   } err_code_e;

endpackage

// File: rtl/shadow_reg_seq_rr_arb.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
module shadow_reg_seq_rr_arb #(
   parameter int NumReq = 4,
   parameter int IdxW   = 2
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              vld_o
);

   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      for (int off = 0; off < NumReq; off++) begin
         j = (int'(ptr_i) + off) % NumReq;
         if (!vld_o && req_i[j]) begin
            vld_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IdxW'(j);
         end
      end
   end

endmodule

// File: rtl/shadow_reg_update_seq.sv
// Arbitrates requesters onto one shadowed register and runs its clear/write/write
// update sequence, reporting the outcome with a one-cycle ack per requester.
module shadow_reg_update_seq
   import shadow_reg_seq_pkg::*;
#(
   parameter int NumReq = 4,
   parameter int DW     = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NumReq-1:0]         req_i,
   input  logic [NumReq-1:0][DW-1:0] wdata_i,
   output logic [NumReq-1:0]         ack_o,
   output logic [1:0]                err_o,
   output logic                      busy_o,
   output logic                      fatal_o,
   output logic                      sh_re_o,
   output logic                      sh_we_o,
   output logic [DW-1:0]             sh_wd_o,
   input  logic                      sh_phase_i,
   input  logic                      sh_err_update_i,
   input  logic                      sh_err_storage_i
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   state_e            state_q, state_d;
   err_code_e         code_q, code_d;
   logic [IdxW-1:0]   ptr_q, ptr_d, idx_q, idx_d, win_idx;
   logic [NumReq-1:0] gnt, arb_req, fack_q, fack_d;
   logic [DW-1:0]     data_q, data_d;
   logic              win_vld, fatal_q;

   function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
      if (int'(i) >= NumReq - 1) return '0;
      return i + IdxW'(1);
   endfunction

   // Masking the requester being acked keeps a still-held request from a double grant.
   assign arb_req = req_i & ~ack_o;

   shadow_reg_seq_rr_arb #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_arb (
      .req_i (arb_req),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (win_idx),
      .vld_o (win_vld)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      data_d  = data_q;
      code_d  = code_q;
      fack_d  = '0;
      sh_re_o = 1'b0;
      sh_we_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               idx_d   = win_idx;
               data_d  = wdata_i[win_idx];
               code_d  = ERR_OK;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            sh_re_o = 1'b1;
            state_d = WR1;
         end
         WR1: begin
            sh_we_o = 1'b1;
            state_d = WR2;
         end
         WR2: begin
            sh_we_o = sh_phase_i;
            if (!sh_phase_i)          code_d = ERR_PHASE;
            else if (sh_err_update_i) code_d = ERR_UPDATE;
            else                      code_d = ERR_OK;
            state_d = RESP;
         end
         RESP: begin
            ptr_d   = inc_idx(idx_q);
            state_d = fatal_q ? FATAL : IDLE;
         end
         FATAL: begin
            if (win_vld) begin
               fack_d = gnt;
               ptr_d  = inc_idx(win_idx);
            end
         end
         default: state_d = IDLE;
      endcase
      // Storage error overrides everything: abort and report on the latched requester.
      if (sh_err_storage_i && state_q != FATAL) begin
         if (state_q inside {CLEAR, WR1, WR2}) begin
            code_d  = ERR_FATAL;
            state_d = RESP;
         end else begin
            state_d = FATAL;
         end
      end
   end

   always_comb begin
      ack_o = '0;
      err_o = ERR_OK;
      if (state_q == RESP) begin
         ack_o[idx_q] = 1'b1;
         err_o        = code_q;
      end else if (state_q == FATAL && |fack_q) begin
         ack_o = fack_q;
         err_o = ERR_FATAL;
      end
   end

   assign sh_wd_o = (state_q inside {WR1, WR2, RESP}) ? data_q : '0;
   assign busy_o  = !(state_q inside {IDLE, FATAL});
   assign fatal_o = fatal_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         code_q  <= ERR_OK;
         fack_q  <= '0;
         fatal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         code_q  <= code_d;
         fack_q  <= fack_d;
         fatal_q <= fatal_q | sh_err_storage_i;
      end
   end

endmodule

// File: tb/tb_shadow_reg_update_seq.sv
// Randomized bench: requesters hold until acked, a behavioural shadow register answers.
module tb_shadow_reg_update_seq;
   import shadow_reg_seq_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [N-1:0]      req_i = '0;
   logic [N-1:0][DW-1:0] wdata_i = '0;
   logic [N-1:0]      ack_o;
   logic [1:0]        err_o;
   logic              busy_o, fatal_o, sh_re_o, sh_we_o;
   logic [DW-1:0]     sh_wd_o;
   logic              sh_phase_i, sh_err_update_i, sh_err_storage_i;

   shadow_reg_update_seq #(.NumReq(N), .DW(DW)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_i            (req_i),
      .wdata_i          (wdata_i),
      .ack_o            (ack_o),
      .err_o            (err_o),
      .busy_o           (busy_o),
      .fatal_o          (fatal_o),
      .sh_re_o          (sh_re_o),
      .sh_we_o          (sh_we_o),
      .sh_wd_o          (sh_wd_o),
      .sh_phase_i       (sh_phase_i),
      .sh_err_update_i  (sh_err_update_i),
      .sh_err_storage_i (sh_err_storage_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   int txn_no = 0;
   logic phase_m;
   int inj_upd = -1, inj_ph = -1;
   logic sto_arm = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;
   always @(posedge clk_i) if (sh_re_o) txn_no <= txn_no + 1;

   // Shadowed register: read clears phase, each write toggles it.
   always @(posedge clk_i or negedge rst_ni)
      if (!rst_ni)      phase_m <= 1'b0;
      else if (sh_re_o) phase_m <= 1'b0;
      else if (sh_we_o) phase_m <= ~phase_m;

   assign sh_phase_i       = (txn_no == inj_ph) ? 1'b0 : phase_m;
   assign sh_err_update_i  = (txn_no == inj_upd) && sh_we_o && phase_m;
   assign sh_err_storage_i = sto_arm && sh_we_o && !phase_m;

   int n_chk = 0, n_pass = 0, both = 0, ptr_m = 0;
   int re_c[$], we_c[$], ak_c[$];
   logic [DW-1:0] we_d[$];
   logic [N-1:0]  ak_v[$];
   logic [1:0]    ak_e[$];
   logic          ak_f[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic step();
      @(negedge clk_i);
      if (sh_re_o) begin
         re_c.push_back(cyc);
         if (sh_we_o) both++;
      end
      if (sh_we_o) begin
         we_c.push_back(cyc);
         we_d.push_back(sh_wd_o);
      end
      if (|ack_o) begin
         ak_c.push_back(cyc);
         ak_v.push_back(ack_o);
         ak_e.push_back(err_o);
         ak_f.push_back(fatal_o);
         req_i = req_i & ~ack_o;
      end
   endtask

   task automatic clr_log();
      re_c.delete(); we_c.delete(); we_d.delete();
      ak_c.delete(); ak_v.delete(); ak_e.delete(); ak_f.delete();
   endtask

   // All requesters in m raise together and hold until acked; fat selects fatal-mode timing.
   task automatic run_batch(input logic [N-1:0] m, input int upd_k, input int ph_k, input bit fat);
      int ord[$];
      int ewc[$];
      logic [DW-1:0] ewd[$];
      logic [N-1:0] rem;
      int p, n, c, lat, sp, guard, e;
      clr_log();
      p   = ptr_m;
      rem = m;
      while (rem != '0) begin
         for (int s = 0; s < N; s++) begin
            int i;
            i = (p + s) % N;
            if (rem[i]) begin
               ord.push_back(i);
               rem[i] = 1'b0;
               p = (i + 1) % N;
               break;
            end
         end
      end
      ptr_m   = p;
      n       = ord.size();
      lat     = fat ? 1 : 4;
      sp      = fat ? 1 : 5;
      inj_upd = (upd_k < 0) ? -1 : txn_no + upd_k + 1;
      inj_ph  = (ph_k < 0) ? -1 : txn_no + ph_k + 1;
      c       = cyc;
      req_i   = m;
      guard   = 0;
      while (req_i != '0 && guard < sp * n + 10) begin
         step();
         guard++;
      end
      step();
      step();
      inj_upd = -1;
      inj_ph  = -1;
      chk("batch_done", 64'(req_i), 64'd0);
      chk("ack_count", 64'(ak_c.size()), 64'(n));
      for (int k = 0; k < n && k < ak_c.size(); k++) begin
         e = fat ? 3 : (k == ph_k) ? 2 : (k == upd_k) ? 1 : 0;
         chk("ack_cycle", 64'(ak_c[k]), 64'(c + lat + sp * k));
         chk("ack_vec", 64'(ak_v[k]), 64'd1 << ord[k]);
         chk("ack_err", 64'(ak_e[k]), 64'(e));
      end
      if (fat) begin
         chk("fatal_no_re", 64'(re_c.size()), 64'd0);
         chk("fatal_no_we", 64'(we_c.size()), 64'd0);
      end else begin
         chk("re_count", 64'(re_c.size()), 64'(n));
         for (int k = 0; k < n && k < re_c.size(); k++)
            chk("re_cycle", 64'(re_c[k]), 64'(c + 1 + sp * k));
         for (int k = 0; k < n; k++) begin
            ewc.push_back(c + 2 + sp * k);
            ewd.push_back(wdata_i[ord[k]]);
            if (k != ph_k) begin
               ewc.push_back(c + 3 + sp * k);
               ewd.push_back(wdata_i[ord[k]]);
            end
         end
         chk("we_count", 64'(we_c.size()), 64'(ewc.size()));
         for (int k = 0; k < ewc.size() && k < we_c.size(); k++) begin
            chk("we_cycle", 64'(we_c[k]), 64'(ewc[k]));
            chk("we_data", 64'(we_d[k]), 64'(ewd[k]));
         end
      end
      chk("busy_after", 64'(busy_o), 64'd0);
   endtask

   initial begin
      int c, r, guard, n;
      logic [N-1:0] m;
      // reset state
      step();
      step();
      chk("rst_ack", 64'(ack_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_fatal", 64'(fatal_o), 64'd0);
      chk("rst_strobes", 64'({sh_re_o, sh_we_o}), 64'd0);
      chk("rst_wd", 64'(sh_wd_o), 64'd0);
      rst_ni = 1'b1;
      step();

      for (int i = 0; i < N; i++) wdata_i[i] = $urandom();
      run_batch(4'b1111, -1, -1, 1'b0);
      wdata_i[0] = 32'hA5A5_0001;
      run_batch(4'b0001, -1, -1, 1'b0);

      // update error on one sequence, then clean follow-up
      for (int i = 0; i < N; i++) wdata_i[i] = $urandom();
      run_batch(4'b0110, 1, -1, 1'b0);
      run_batch(4'b0100, -1, -1, 1'b0);
      // phase error: single write pulse
      run_batch(4'b1001, -1, 0, 1'b0);

      for (int it = 0; it < 20; it++) begin
         m = N'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) wdata_i[i] = $urandom();
         n = $countones(m);
         run_batch(m, int'($urandom_range(0, n)) - 1, int'($urandom_range(0, n)) - 1, 1'b0);
      end

      // reset in the middle of WR1
      run_batch(4'b0100, -1, -1, 1'b0);
      req_i = 4'b0001;
      step();
      step();
      chk("wr1_we_seen", 64'(sh_we_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("arst_we", 64'(sh_we_o), 64'd0);
      chk("arst_re", 64'(sh_re_o), 64'd0);
      chk("arst_wd", 64'(sh_wd_o), 64'd0);
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_ack", 64'(ack_o), 64'd0);
      req_i = '0;
      step();
      rst_ni = 1'b1;
      ptr_m  = 0;
      step();
      for (int i = 0; i < N; i++) wdata_i[i] = $urandom();
      run_batch(4'b1010, -1, -1, 1'b0);

      // storage error during WR1
      clr_log();
      r = $urandom_range(0, N - 1);
      wdata_i[r] = $urandom();
      sto_arm = 1'b1;
      c = cyc;
      req_i = N'(1 << r);
      guard = 0;
      while (req_i != '0 && guard < 12) begin
         step();
         guard++;
      end
      for (int k = 0; k < 4; k++) step();
      sto_arm = 1'b0;
      chk("sto_done", 64'(req_i), 64'd0);
      chk("sto_ack_count", 64'(ak_c.size()), 64'd1);
      if (ak_c.size() > 0) begin
         chk("sto_ack_cycle", 64'(ak_c[0]), 64'(c + 3));
         chk("sto_ack_vec", 64'(ak_v[0]), 64'd1 << r);
         chk("sto_ack_err", 64'(ak_e[0]), 64'(ERR_FATAL));
         chk("sto_fatal_at_ack", 64'(ak_f[0]), 64'd1);
      end
      chk("sto_re_count", 64'(re_c.size()), 64'd1);
      chk("sto_we_count", 64'(we_c.size()), 64'd1);
      chk("sto_fatal", 64'(fatal_o), 64'd1);
      chk("sto_busy", 64'(busy_o), 64'd0);
      ptr_m = (r + 1) % N;

      run_batch(4'b0010, -1, -1, 1'b1);
      for (int it = 0; it < 4; it++) run_batch(N'($urandom_range(1, 15)), -1, -1, 1'b1);
      chk("fatal_sticky", 64'(fatal_o), 64'd1);

      rst_ni = 1'b0;
      step();
      chk("fatal_cleared", 64'(fatal_o), 64'd0);
      rst_ni = 1'b1;
      ptr_m  = 0;
      step();
      run_batch(4'b0001, -1, -1, 1'b0);
      chk("re_we_exclusive", 64'(both), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
